function_task: RTL and testbench
================================

FUNCTION_TASK -- requirements
Module: function_task

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits, two's-complement signed; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 a  input  WIDTH  signed operand A.
REQ-005 b  input  WIDTH  signed operand B.
REQ-006 m  output  1  registered compare flag: 1 when a > b (signed).
REQ-007 n  output  WIDTH  registered signed saturating sum of a and b.
REQ-008 Both outputs shall be driven directly from flip-flops, with no combinational path from a or b to m or n.

Function
REQ-009 Compare: on each rising clk edge with rst low, m shall load 1 if signed(a) > signed(b), else 0.
REQ-010 The compare shall be signed two's-complement, never unsigned (e.g. a=-1, b=1 -> m=0).
REQ-011 Equal operands shall give m=0.
REQ-012 Sum: on the same edge, n shall load the saturated signed sum of a and b.
REQ-013 Sum width: the sum shall be formed at WIDTH+1 bits with sign extension of both operands before clamping.
REQ-014 Positive clamp: a sum above 2^(WIDTH-1)-1 shall give n = 2^(WIDTH-1)-1 (WIDTH=4: 7).
REQ-015 Negative clamp: a sum below -2^(WIDTH-1) shall give n = -2^(WIDTH-1) (WIDTH=4: -8).
REQ-016 In-range sums shall pass through unchanged.
REQ-017 Latency: exactly one clock; outputs shall reflect the operands sampled at the immediately preceding rising edge.
REQ-018 Inputs may change on the same edge they are sampled; the value present at setup time is used.
REQ-019 The compare shall be a pure side-effect-free function of (a, b).
REQ-020 The saturation shall be a reusable procedure returning the clamped value; both shall be instantiated once per clock.
REQ-021 There is no enable and no handshake; a new result is produced every cycle.

Reset
REQ-022 While rst is high, m shall be 0 and n shall be 0 immediately, with no clk edge required.
REQ-023 Assertion mid-operation shall override any pending update.
REQ-024 On deassertion, the first rising clk edge with rst low shall load a valid result from the current a, b.
REQ-025 No X shall appear on m or n after reset has been applied once.

Verification
REQ-026 Reset: assert rst between clk edges -> m=0, n=0 immediately; both hold at 0 across two clk edges while rst stays high.
REQ-027 Signed compare: a=-5 (4'b1011), b=2 -> next edge m=0, n=-3; then a=2, b=-5 -> m=1, n=-3.
REQ-028 Saturation: a=7, b=1 -> n=7, m=1; a=-8, b=-1 -> n=-8, m=0; a=-8, b=7 -> n=-1, m=0.
REQ-029 Small-operand sweep: all nine pairs from a, b in {-1, 0, 1} changed every rising edge -> each cycle m = (a>b), n = a+b, one cycle late; e.g. a=1, b=1 -> m=0, n=2; a=-1, b=-1 -> m=0, n=-2.
REQ-030 Equality and latency: a=b=3 -> m=0, n=6, appearing exactly one edge after the change and not before.
REQ-031 Reset mid-stream: rst asserted while a=7, b=7 -> n=0 at once; after release, next edge -> n=7, m=0.

Source files
------------

// File: rtl/function_task.sv
// Registered signed compare and saturating add of two WIDTH-bit operands.
// Both outputs come straight from flops and update every clock with one cycle of latency.
module function_task #(
   parameter int WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic                    m,
   output logic signed [WIDTH-1:0] n
);

   logic                    m_d;
   logic                    m_q;
   logic signed [WIDTH-1:0] n_d;
   logic signed [WIDTH-1:0] n_q;
   logic signed [WIDTH:0]   sum_wide;

   function automatic logic is_greater(input logic signed [WIDTH-1:0] x,
                                       input logic signed [WIDTH-1:0] y);
      return x > y;
   endfunction

   // Overflow shows up as the two top bits of the widened sum disagreeing.
   function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH:0] s);
      logic signed [WIDTH-1:0] r;
      if (s[WIDTH] == s[WIDTH-1]) begin
         r = s[WIDTH-1:0];
      end else if (s[WIDTH] == 1'b0) begin
         r = {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         r = {1'b1, {(WIDTH-1){1'b0}}};
      end
      return r;
   endfunction

   always_comb begin
      sum_wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      m_d      = is_greater(a, b);
      n_d      = saturate(sum_wide);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q <= 1'b0;
         n_q <= '0;
      end else begin
         m_q <= m_d;
         n_q <= n_d;
      end
   end

   assign m = m_q;
   assign n = n_q;

endmodule

// File: tb/tb_function_task.sv
// Self-checking bench for function_task at WIDTH=4: directed vector table plus
// hand-written sequences for latency and asynchronous reset behaviour.
module tb_function_task;

   localparam int WIDTH = 4;

   typedef struct {
      logic signed [WIDTH-1:0] a;
      logic signed [WIDTH-1:0] b;
      logic                    m;
      logic signed [WIDTH-1:0] n;
   } vec_t;

   logic                    clk;
   logic                    rst;
   logic signed [WIDTH-1:0] a;
   logic signed [WIDTH-1:0] b;
   logic                    m;
   logic signed [WIDTH-1:0] n;

   int testsRun;
   int testsFailed;

   vec_t vecs[18];

   function_task #(.WIDTH(WIDTH)) dut (
      .clk(clk),
      .rst(rst),
      .a  (a),
      .b  (b),
      .m  (m),
      .n  (n)
   );

   // Free-running 10-time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run can never hang
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Builds one table record from plain integers, expected values worked out by hand
   function automatic vec_t makeVec(input int va, input int vb, input int vm, input int vn);
      vec_t v;
      v.a = WIDTH'(va);
      v.b = WIDTH'(vb);
      v.m = 1'(vm);
      v.n = WIDTH'(vn);
      return v;
   endfunction

   // Drive operands mid-cycle, then let one rising edge capture them and settle
   task automatic applyStimulus(input logic signed [WIDTH-1:0] va,
                                input logic signed [WIDTH-1:0] vb);
      @(negedge clk);
      a = va;
      b = vb;
      @(posedge clk);
      #1;
   endtask

   // Compare both outputs against the expected pair; one comparison per call
   task automatic checkOutput(input string name, input logic expM,
                              input logic signed [WIDTH-1:0] expN);
      testsRun++;
      if (m !== expM || n !== expN) begin
         testsFailed++;
         $display("[TB] FAIL %s: got m=%0b n=%0d, expected m=%0b n=%0d",
                  name, m, n, expM, expN);
      end
   endtask

   // Main sequence: reset, vector table, latency check, mid-stream reset
   initial begin
      testsRun    = 0;
      testsFailed = 0;

      vecs[0]  = makeVec(-5,  2, 0, -3);
      vecs[1]  = makeVec( 2, -5, 1, -3);
      vecs[2]  = makeVec( 7,  1, 1,  7);
      vecs[3]  = makeVec(-8, -1, 0, -8);
      vecs[4]  = makeVec(-8,  7, 0, -1);
      vecs[5]  = makeVec(-1, -1, 0, -2);
      vecs[6]  = makeVec(-1,  0, 0, -1);
      vecs[7]  = makeVec(-1,  1, 0,  0);
      vecs[8]  = makeVec( 0, -1, 1, -1);
      vecs[9]  = makeVec( 0,  0, 0,  0);
      vecs[10] = makeVec( 0,  1, 0,  1);
      vecs[11] = makeVec( 1, -1, 1,  0);
      vecs[12] = makeVec( 1,  0, 1,  1);
      vecs[13] = makeVec( 1,  1, 0,  2);
      vecs[14] = makeVec(-8, -8, 0, -8);
      vecs[15] = makeVec(-4, -4, 0, -8);
      vecs[16] = makeVec( 3,  4, 0,  7);
      vecs[17] = makeVec( 7, -8, 1, -1);

      rst = 1'b1;
      a   = 4'sd5;
      b   = -4'sd3;
      #1;
      checkOutput("reset_initial", 1'b0, 4'sd0);
      @(posedge clk);
      #1;
      checkOutput("reset_hold", 1'b0, 4'sd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("first_after_release", 1'b1, 4'sd2);

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b);
         checkOutput($sformatf("vec%0d(a=%0d,b=%0d)", i, vecs[i].a, vecs[i].b),
                     vecs[i].m, vecs[i].n);
      end

      applyStimulus(4'sd1, 4'sd1);
      checkOutput("latency_pre", 1'b0, 4'sd2);
      @(negedge clk);
      a = 4'sd3;
      b = 4'sd3;
      #1;
      checkOutput("latency_not_before_edge", 1'b0, 4'sd2);
      @(posedge clk);
      #1;
      checkOutput("latency_equal_3_3", 1'b0, 4'sd6);

      applyStimulus(4'sd7, 4'sd7);
      checkOutput("midstream_7_7", 1'b0, 4'sd7);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midstream_reset_immediate", 1'b0, 4'sd0);
      @(posedge clk);
      #1;
      checkOutput("midstream_reset_hold1", 1'b0, 4'sd0);
      @(posedge clk);
      #1;
      checkOutput("midstream_reset_hold2", 1'b0, 4'sd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midstream_release", 1'b0, 4'sd7);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
